mem_sequencer: RTL
==================

MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 SHALL have parameter WAIT_MAX, default 255, max cycles in a WAIT state before timeout (1..65535).
REQ-003 SHALL have parameter HOLD_CYCLES, default 50000000, cycles READ_DONE persists before returning to IDLE (>=1).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 rd_req  input  1  read request, level, sampled in IDLE only.
REQ-007 wr_req  input  1  write request, level, sampled in IDLE only.
REQ-008 req_addr  input  ADDR_W  request address.
REQ-009 req_wdata  input  16  write data.
REQ-010 mem_addr  output  ADDR_W  registered memory address.
REQ-011 mem_wdata  output  16  registered write data.
REQ-012 mem_cs / mem_oe / mem_we  output  1 each  memory chip select, output enable, write enable, active-high, registered.
REQ-013 mem_rdata  input  16  memory read data.
REQ-014 mem_ready  input  1  memory completion strobe.
REQ-015 state  output  12  one-hot FSM state, consumed directly by the 7-segment state display.
REQ-016 rd_data  output  16  last captured read value.
REQ-017 busy  output  1  high whenever state != IDLE.
REQ-018 err  output  1  sticky timeout flag.

Function
REQ-019 state encoding SHALL be: IDLE=bit0, READ_ST0=bit1, READ_ST1=bit2, READ_ST2=bit3, READ_WAIT=bit4, READ_DONE=bit5, WRITE_ST0=bit6, WRITE_ST1=bit7, WRITE_ST2=bit8, WRITE_ST3=bit9, WRITE_ST4=bit10, WRITE_WAIT=bit11; exactly one bit high at all times.
REQ-020 IDLE: rd_req=1 -> READ_ST0; else wr_req=1 -> WRITE_ST0; both high -> read wins; err SHALL be cleared on leaving IDLE for a new request.
REQ-021 Leaving IDLE SHALL latch req_addr into mem_addr (and req_wdata into mem_wdata for writes); later changes on req_* SHALL NOT affect the transaction.
REQ-022 Read: READ_ST0 (addr stable, strobes low) -> READ_ST1 (cs=1) -> READ_ST2 (cs=1, oe=1) -> READ_WAIT (cs=1, oe=1), one cycle each except WAIT.
REQ-023 READ_WAIT: mem_ready=1 -> capture mem_rdata into rd_data on that edge, go READ_DONE, drop cs/oe.
REQ-024 READ_DONE SHALL last exactly HOLD_CYCLES cycles, then IDLE; requests during READ_DONE ignored.
REQ-025 Write: WRITE_ST0 (addr/data stable) -> WRITE_ST1 (cs=1) -> WRITE_ST2 (cs=1, we=1) -> WRITE_ST3 (cs=1, we=1) -> WRITE_ST4 (cs=1, we=0) -> WRITE_WAIT (cs=1), one cycle each except WAIT.
REQ-026 WRITE_WAIT: mem_ready=1 -> IDLE, cs drops.
REQ-027 mem_ready outside WAIT states SHALL be ignored.
REQ-028 A 16-bit wait counter SHALL clear on WAIT entry and increment each WAIT cycle without mem_ready; reaching WAIT_MAX SHALL set err, drop all strobes, go IDLE; rd_data unchanged on read timeout.
REQ-029 mem_ready on the same cycle the counter reaches WAIT_MAX SHALL count as success (no err).
REQ-030 HOLD counter SHALL be wide enough for HOLD_CYCLES and SHALL NOT wrap.
REQ-031 Illegal state (not one-hot) SHALL recover to IDLE on the next edge, strobes low.
REQ-032 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-033 rst=1 SHALL immediately force state=IDLE (12'h001), mem_cs/oe/we=0, mem_addr=0, mem_wdata=0, rd_data=0, busy=0, err=0, counters=0, regardless of clock.
REQ-034 Reset asserted mid-transaction SHALL abort it; strobes low within the reset assertion, no completion recorded.
REQ-035 After rst deasserts, first transition SHALL occur no earlier than the next rising clk edge.

Verification
REQ-036 rd_req pulse, req_addr=16'h0042, mem_ready 3 cycles into READ_WAIT with mem_rdata=16'hBEEF -> state visits 002,004,008,010,020; rd_data=16'hBEEF; IDLE after HOLD_CYCLES (bench HOLD_CYCLES=4).
REQ-037 wr_req, addr=16'h0010, wdata=16'h1234, ready 1 cycle into WRITE_WAIT -> we high exactly 2 cycles (ST2,ST3), mem_wdata=16'h1234, back to IDLE, err=0.
REQ-038 rd_req and wr_req both high in IDLE -> READ_ST0 entered, no we pulse.
REQ-039 WAIT_MAX=8, never assert mem_ready on read -> err=1 after 8 WAIT cycles, IDLE, rd_data retains prior value; next request clears err.
REQ-040 Assert rst during WRITE_ST2 (we=1) -> we=0 and state=12'h001 asynchronously before next clk edge.
REQ-041 Change req_addr to 16'hFFFF during READ_ST1 -> mem_addr remains original value through READ_DONE.

Source files
------------

// File: rtl/mem_sequencer.sv
// mem_sequencer: sequences single read/write accesses to an asynchronous
// SRAM-style memory with explicit setup/strobe/hold phases.
//
// Ports:
//   clk, rst              clock (rising edge) and asynchronous active-high reset
//   rd_req, wr_req        level requests, only looked at while idle (read wins)
//   req_addr, req_wdata   request address / write data, latched on accept
//   mem_addr, mem_wdata   registered address / write data to the memory
//   mem_cs, mem_oe, mem_we  registered active-high memory strobes
//   mem_rdata, mem_ready  memory read data and completion strobe
//   state                 one-hot FSM state for the 7-segment display
//   rd_data               last successfully captured read value
//   busy                  high whenever the FSM is not idle
//   err                   sticky wait-timeout flag, cleared by the next request
module mem_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int WAIT_MAX    = 255,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic              mem_we,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [11:0]       state,
  output logic [15:0]       rd_data,
  output logic              busy,
  output logic              err
);

  typedef enum logic [11:0] {
    S_IDLE       = 12'h001,
    S_READ_ST0   = 12'h002,
    S_READ_ST1   = 12'h004,
    S_READ_ST2   = 12'h008,
    S_READ_WAIT  = 12'h010,
    S_READ_DONE  = 12'h020,
    S_WRITE_ST0  = 12'h040,
    S_WRITE_ST1  = 12'h080,
    S_WRITE_ST2  = 12'h100,
    S_WRITE_ST3  = 12'h200,
    S_WRITE_ST4  = 12'h400,
    S_WRITE_WAIT = 12'h800
  } state_t;

  // Hold counter only ever counts up to HOLD_CYCLES-1, so it cannot wrap.
  localparam int                HOLD_W       = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] LP_HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LP_HOLD_ONE  = HOLD_W'(1);
  localparam logic [15:0]       LP_WAIT_MAX  = 16'(WAIT_MAX);

  state_t              r_state, w_state_next;
  logic [15:0]         r_wait_cnt, w_wait_cnt_next, w_wait_inc;
  logic [HOLD_W-1:0]   r_hold_cnt, w_hold_cnt_next;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [15:0]         r_mem_wdata, r_rd_data;
  logic                r_mem_cs, r_mem_oe, r_mem_we, r_busy, r_err;
  logic                w_cs_next, w_oe_next, w_we_next;
  logic                w_start_rd, w_start_wr, w_capture, w_timeout;

  assign w_wait_inc = r_wait_cnt + 16'd1;

  // Next-state logic. Counters default to zero so they are automatically
  // cleared on entry to the WAIT / DONE states.
  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = '0;
    w_hold_cnt_next = '0;
    w_start_rd      = 1'b0;
    w_start_wr      = 1'b0;
    w_capture       = 1'b0;
    w_timeout       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rd_req) begin
          w_state_next = S_READ_ST0;
          w_start_rd   = 1'b1;
        end else if (wr_req) begin
          w_state_next = S_WRITE_ST0;
          w_start_wr   = 1'b1;
        end
      end
      S_READ_ST0: w_state_next = S_READ_ST1;
      S_READ_ST1: w_state_next = S_READ_ST2;
      S_READ_ST2: w_state_next = S_READ_WAIT;
      S_READ_WAIT: begin
        // mem_ready has priority over the timeout on the final wait cycle
        if (mem_ready) begin
          w_state_next = S_READ_DONE;
          w_capture    = 1'b1;
        end else if (w_wait_inc == LP_WAIT_MAX) begin
          w_state_next = S_IDLE;
          w_timeout    = 1'b1;
        end else begin
          w_wait_cnt_next = w_wait_inc;
        end
      end
      S_READ_DONE: begin
        if (r_hold_cnt == LP_HOLD_LAST) w_state_next = S_IDLE;
        else w_hold_cnt_next = r_hold_cnt + LP_HOLD_ONE;
      end
      S_WRITE_ST0: w_state_next = S_WRITE_ST1;
      S_WRITE_ST1: w_state_next = S_WRITE_ST2;
      S_WRITE_ST2: w_state_next = S_WRITE_ST3;
      S_WRITE_ST3: w_state_next = S_WRITE_ST4;
      S_WRITE_ST4: w_state_next = S_WRITE_WAIT;
      S_WRITE_WAIT: begin
        if (mem_ready) begin
          w_state_next = S_IDLE;
        end else if (w_wait_inc == LP_WAIT_MAX) begin
          w_state_next = S_IDLE;
          w_timeout    = 1'b1;
        end else begin
          w_wait_cnt_next = w_wait_inc;
        end
      end
      // Any non-one-hot value falls back to idle with strobes low.
      default: w_state_next = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered alongside it, so
  // they change on the same edge as the state and never glitch.
  always_comb begin
    w_cs_next = 1'b0;
    w_oe_next = 1'b0;
    w_we_next = 1'b0;
    case (w_state_next)
      S_READ_ST1:                 w_cs_next = 1'b1;
      S_READ_ST2, S_READ_WAIT: begin
        w_cs_next = 1'b1;
        w_oe_next = 1'b1;
      end
      S_WRITE_ST2, S_WRITE_ST3: begin
        w_cs_next = 1'b1;
        w_we_next = 1'b1;
      end
      S_WRITE_ST1, S_WRITE_ST4, S_WRITE_WAIT: w_cs_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_hold_cnt  <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_data   <= '0;
      r_mem_cs    <= 1'b0;
      r_mem_oe    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_hold_cnt <= w_hold_cnt_next;
      r_mem_cs   <= w_cs_next;
      r_mem_oe   <= w_oe_next;
      r_mem_we   <= w_we_next;
      r_busy     <= (w_state_next != S_IDLE);
      if (w_start_rd || w_start_wr) begin
        r_mem_addr <= req_addr;
        r_err      <= 1'b0;
      end
      if (w_start_wr) r_mem_wdata <= req_wdata;
      if (w_capture)  r_rd_data   <= mem_rdata;
      if (w_timeout)  r_err       <= 1'b1;
    end
  end

  assign state     = r_state;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_cs    = r_mem_cs;
  assign mem_oe    = r_mem_oe;
  assign mem_we    = r_mem_we;
  assign rd_data   = r_rd_data;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule
